// File: rtl/cache_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cache_ctrl_pkg
// Shared types and constants for the L1 cache controller:
//   cache_state_t    - controller sequencing states
//   DWMUX_*          - datawritemux_sel encodings (PMDR line / CPU-merged line)
//   PADDR_*          - pmemaddrmux_sel encodings (CPU address / writeback address)
// -----------------------------------------------------------------------------
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    INSTALL   = 3'd4
  } cache_state_t;

  localparam logic DWMUX_PMDR = 1'b0;
  localparam logic DWMUX_CPU  = 1'b1;
  localparam logic PADDR_CPU  = 1'b0;
  localparam logic PADDR_WB   = 1'b1;

endpackage : cache_ctrl_pkg

// File: rtl/cache_perf_counter.sv
// -----------------------------------------------------------------------------
// cache_perf_counter
// Free-running event counter that wraps modulo 2^s_count.
//   clk   - system clock
//   rst   - synchronous active-high clear
//   inc   - add one on this edge
//   count - current value
// -----------------------------------------------------------------------------
module cache_perf_counter #(
  parameter int unsigned s_count = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [s_count-1:0] count
);

  // NOTE: sequential state is only ever assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + s_count'(1);
    end
  end

endmodule : cache_perf_counter

// File: rtl/cache_control.sv
// -----------------------------------------------------------------------------
// cache_control
// Sequencing FSM for a two-way, write-back, write-allocate L1 cache datapath.
// Turns CPU requests into array/LRU/dirty strobes, runs writeback and fill
// bursts on the physical-memory port and keeps hit/miss/writeback counters.
//
// Ports
//   clk, rst                 - clock, synchronous active-high reset
//   mem_read, mem_write      - CPU request (held until mem_resp)
//   mem_resp                 - one-cycle CPU completion pulse
//   hit, eviction            - datapath tag match / LRU-way dirty bit
//   array_read, array_load   - datapath array read / write enables
//   lru_load, dirty_load     - LRU and dirty-bit update strobes
//   pmdr_load                - capture pmem_rdata into PMDR
//   datawritemux_sel         - 0 PMDR line, 1 CPU-merged line
//   adaptermux_sel           - 0 array line to CPU, 1 PMDR line to CPU
//   pmemaddrmux_sel          - 0 CPU address, 1 writeback address
//   pmem_read, pmem_write    - physical memory request (held until pmem_resp)
//   pmem_resp                - physical memory completion pulse
//   hit_count, miss_count,
//   wb_count                 - wrapping performance counters
// -----------------------------------------------------------------------------
module cache_control
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned s_count = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic               mem_resp,
  input  logic               hit,
  input  logic               eviction,
  output logic               array_read,
  output logic               array_load,
  output logic               lru_load,
  output logic               dirty_load,
  output logic               pmdr_load,
  output logic               datawritemux_sel,
  output logic               adaptermux_sel,
  output logic               pmemaddrmux_sel,
  output logic               pmem_read,
  output logic               pmem_write,
  input  logic               pmem_resp,
  output logic [s_count-1:0] hit_count,
  output logic [s_count-1:0] miss_count,
  output logic [s_count-1:0] wb_count
);

  cache_state_t state, state_next;
  logic         hit_inc, miss_inc, wb_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A miss always finishes by returning to IDLE, so the still-pending request
  // is looked up again and completes through the ordinary hit path.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:      if (mem_read || mem_write) state_next = CHECK;
      CHECK:     if (hit)                   state_next = IDLE;
                 else if (eviction)         state_next = WRITEBACK;
                 else                       state_next = FILL;
      WRITEBACK: if (pmem_resp)             state_next = FILL;
      FILL:      if (pmem_resp)             state_next = INSTALL;
      INSTALL:                              state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_resp         = 1'b0;
    array_read       = 1'b0;
    array_load       = 1'b0;
    lru_load         = 1'b0;
    dirty_load       = 1'b0;
    pmdr_load        = 1'b0;
    datawritemux_sel = DWMUX_PMDR;
    adaptermux_sel   = 1'b0;
    pmemaddrmux_sel  = PADDR_CPU;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    wb_inc           = 1'b0;

    unique case (state)
      IDLE: begin
        array_read = 1'b1;
      end
      CHECK: begin
        if (hit) begin
          hit_inc  = 1'b1;
          mem_resp = 1'b1;
          lru_load = 1'b1;
          // A write (including read+write together) merges CPU data into the
          // array line and marks it dirty.
          if (mem_write) begin
            array_load       = 1'b1;
            datawritemux_sel = DWMUX_CPU;
            dirty_load       = 1'b1;
          end
        end else begin
          miss_inc = 1'b1;
        end
      end
      WRITEBACK: begin
        pmem_write      = 1'b1;
        pmemaddrmux_sel = PADDR_WB;
        wb_inc          = pmem_resp;
      end
      FILL: begin
        pmem_read       = 1'b1;
        pmemaddrmux_sel = PADDR_CPU;
        pmdr_load       = pmem_resp;
      end
      INSTALL: begin
        // dirty datain is mem_write: a read fill installs clean, a write fill
        // installs dirty ahead of the merge on the following hit.
        array_load       = 1'b1;
        datawritemux_sel = DWMUX_PMDR;
        dirty_load       = 1'b1;
      end
      default: ;
    endcase
  end

  cache_perf_counter #(.s_count(s_count)) u_hit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  cache_perf_counter #(.s_count(s_count)) u_miss_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

  cache_perf_counter #(.s_count(s_count)) u_wb_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule : cache_control

// File: tb/tb_cache_control.sv
// -----------------------------------------------------------------------------
// tb_cache_control
// Drives CPU transactions as timelines of phases (idle, lookup, writeback
// burst, fill burst, install) and compares the controller outputs each cycle
// against the values each phase requires. Counters are tracked as plain
// integers. A second instance with 4-bit counters shares all inputs and is
// used to observe counter wrap.
// -----------------------------------------------------------------------------
module tb_cache_control;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write, hit, eviction, pmem_resp;

  logic        mem_resp, array_read, array_load, lru_load, dirty_load, pmdr_load;
  logic        datawritemux_sel, adaptermux_sel, pmemaddrmux_sel, pmem_read, pmem_write;
  logic [31:0] hit_count, miss_count, wb_count;

  logic        s_mem_resp, s_array_read, s_array_load, s_lru_load, s_dirty_load, s_pmdr_load;
  logic        s_dwm, s_adm, s_pam, s_pmem_read, s_pmem_write;
  logic [3:0]  s_hit_count, s_miss_count, s_wb_count;

  always #5 clk = ~clk;

  cache_control u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .hit(hit), .eviction(eviction),
    .array_read(array_read), .array_load(array_load), .lru_load(lru_load),
    .dirty_load(dirty_load), .pmdr_load(pmdr_load),
    .datawritemux_sel(datawritemux_sel), .adaptermux_sel(adaptermux_sel),
    .pmemaddrmux_sel(pmemaddrmux_sel), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  cache_control #(.s_count(4)) u_dut_small (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(s_mem_resp), .hit(hit), .eviction(eviction),
    .array_read(s_array_read), .array_load(s_array_load), .lru_load(s_lru_load),
    .dirty_load(s_dirty_load), .pmdr_load(s_pmdr_load),
    .datawritemux_sel(s_dwm), .adaptermux_sel(s_adm),
    .pmemaddrmux_sel(s_pam), .pmem_read(s_pmem_read),
    .pmem_write(s_pmem_write), .pmem_resp(pmem_resp),
    .hit_count(s_hit_count), .miss_count(s_miss_count), .wb_count(s_wb_count)
  );

  // Timeline phases of a transaction as seen from the CPU/pmem side.
  localparam int P_IDLE = 0, P_CHECK_HIT = 1, P_CHECK_MISS = 2,
                 P_WB = 3, P_FILL = 4, P_INSTALL = 5;

  int passed = 0;
  int total  = 0;
  int m_hits = 0, m_misses = 0, m_wbs = 0;

  // Observed output vector, MSB first:
  // mem_resp array_read array_load lru_load dirty_load pmdr_load dwm adm pam pmem_read pmem_write
  wire [10:0] outs = {mem_resp, array_read, array_load, lru_load, dirty_load, pmdr_load,
                      datawritemux_sel, adaptermux_sel, pmemaddrmux_sel, pmem_read, pmem_write};

  function automatic logic [10:0] expect_out(int ph, bit wr, bit presp);
    logic [10:0] v = '0;
    case (ph)
      P_IDLE:       v[9] = 1'b1;
      P_CHECK_HIT:  begin
        v[10] = 1'b1; v[7] = 1'b1;
        if (wr) begin v[8] = 1'b1; v[6] = 1'b1; v[4] = 1'b1; end
      end
      P_CHECK_MISS: v = '0;
      P_WB:         begin v[0] = 1'b1; v[2] = 1'b1; end
      P_FILL:       begin v[1] = 1'b1; v[5] = presp; end
      P_INSTALL:    begin v[8] = 1'b1; v[6] = 1'b1; end
      default:      v = '0;
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    hit = 1'b0; eviction = 1'b0; pmem_resp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hits = 0; m_misses = 0; m_wbs = 0;
  endtask

  // Called at posedge+1; drives one cycle, checks at negedge, returns at next posedge+1.
  task automatic step_check(string name, int idx, int ph, bit wr, bit presp, bit ev);
    hit = (ph == P_CHECK_HIT); eviction = ev; pmem_resp = presp;
    @(negedge clk);
    total++;
    if (outs !== expect_out(ph, wr, presp))
      $display("FAIL %s cycle %0d phase %0d: outputs got %b want %b",
               name, idx, ph, outs, expect_out(ph, wr, presp));
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic check_counters(string name);
    total++;
    if (hit_count !== 32'(m_hits)) $display("FAIL %s hit_count got %0d want %0d", name, hit_count, m_hits);
    else passed++;
    total++;
    if (miss_count !== 32'(m_misses)) $display("FAIL %s miss_count got %0d want %0d", name, miss_count, m_misses);
    else passed++;
    total++;
    if (wb_count !== 32'(m_wbs)) $display("FAIL %s wb_count got %0d want %0d", name, wb_count, m_wbs);
    else passed++;
    total++;
    if ({s_hit_count, s_miss_count, s_wb_count} !== {4'(m_hits), 4'(m_misses), 4'(m_wbs)})
      $display("FAIL %s small counters got %0d/%0d/%0d want %0d/%0d/%0d", name,
               s_hit_count, s_miss_count, s_wb_count, m_hits % 16, m_misses % 16, m_wbs % 16);
    else passed++;
  endtask

  // One complete CPU transaction. Starts and ends at posedge+1 in IDLE.
  task automatic run_txn(string name, bit rd, bit wr, bit first_hit, bit ev,
                         int m, int n, bit rand_resp, bit chk_cnt);
    int phases[$];
    bit resps[$];
    int exp_lat, resp_at;
    phases.push_back(P_IDLE); resps.push_back(rand_resp ? 1'($urandom_range(1)) : 1'b0);
    if (first_hit) begin
      phases.push_back(P_CHECK_HIT); resps.push_back(rand_resp ? 1'($urandom_range(1)) : 1'b0);
      exp_lat = 2;
    end else begin
      phases.push_back(P_CHECK_MISS); resps.push_back(rand_resp ? 1'($urandom_range(1)) : 1'b0);
      if (ev) for (int i = 0; i < m; i++) begin phases.push_back(P_WB); resps.push_back(i == m - 1); end
      for (int i = 0; i < n; i++) begin phases.push_back(P_FILL); resps.push_back(i == n - 1); end
      phases.push_back(P_INSTALL);   resps.push_back(rand_resp ? 1'($urandom_range(1)) : 1'b0);
      phases.push_back(P_IDLE);      resps.push_back(rand_resp ? 1'($urandom_range(1)) : 1'b0);
      phases.push_back(P_CHECK_HIT); resps.push_back(rand_resp ? 1'($urandom_range(1)) : 1'b0);
      exp_lat = n + 5 + (ev ? m : 0);
    end
    mem_read = rd; mem_write = wr;
    resp_at = -1;
    for (int i = 0; i < phases.size(); i++) begin
      hit = (phases[i] == P_CHECK_HIT); eviction = ev; pmem_resp = resps[i];
      @(negedge clk);
      if (mem_resp === 1'b1 && resp_at < 0) resp_at = i;
      total++;
      if (outs !== expect_out(phases[i], wr, resps[i]))
        $display("FAIL %s cycle %0d phase %0d: outputs got %b want %b",
                 name, i, phases[i], outs, expect_out(phases[i], wr, resps[i]));
      else passed++;
      @(posedge clk); #1;
    end
    total++;
    if (resp_at + 1 != exp_lat)
      $display("FAIL %s latency: got %0d cycles want %0d", name, resp_at + 1, exp_lat);
    else passed++;
    // Reference counter update for this transaction.
    m_hits++;
    if (!first_hit) begin m_misses++; if (ev) m_wbs++; end
    mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== expect_out(P_IDLE, 1'b0, 1'b0))
      $display("FAIL %s back-to-idle: outputs got %b want %b", name, outs, expect_out(P_IDLE, 1'b0, 1'b0));
    else passed++;
    if (chk_cnt) check_counters(name);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if (outs !== expect_out(P_IDLE, 1'b0, 1'b0))
      $display("FAIL reset outputs got %b want %b", outs, expect_out(P_IDLE, 1'b0, 1'b0));
    else passed++;
    check_counters("reset");
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss();
    do_reset();
    run_txn("read_miss", 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0, 1'b1);
  endtask

  task automatic test_write_hit();
    run_txn("write_hit", 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_dirty_miss();
    run_txn("dirty_miss", 1'b1, 1'b0, 1'b0, 1'b1, 2, 2, 1'b0, 1'b1);
  endtask

  task automatic test_both_high();
    run_txn("rd_wr_hit", 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    run_txn("rd_wr_miss", 1'b1, 1'b1, 1'b0, 1'b1, 1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    mem_read = 1'b1; mem_write = 1'b0;
    step_check("mid_fill", 0, P_IDLE, 1'b0, 1'b0, 1'b0);
    step_check("mid_fill", 1, P_CHECK_MISS, 1'b0, 1'b0, 1'b0);
    step_check("mid_fill", 2, P_FILL, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step_check("mid_fill", 3, P_FILL, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; mem_read = 1'b0;
    m_hits = 0; m_misses = 0; m_wbs = 0;
    @(negedge clk);
    total++;
    if (pmem_read !== 1'b0) $display("FAIL mid_fill pmem_read got %b want 0", pmem_read);
    else passed++;
    total++;
    if (outs !== expect_out(P_IDLE, 1'b0, 1'b0))
      $display("FAIL mid_fill idle outputs got %b want %b", outs, expect_out(P_IDLE, 1'b0, 1'b0));
    else passed++;
    check_counters("mid_fill");
    @(posedge clk); #1;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) run_txn("wrap_hit", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (s_hit_count !== 4'd0) $display("FAIL wrap small hit_count got %0d want 0", s_hit_count);
    else passed++;
    check_counters("wrap");
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      bit rd, wr;
      int idle;
      rd = 1'($urandom_range(1)); wr = 1'($urandom_range(1));
      if (!rd && !wr) rd = 1'b1;
      run_txn("random", rd, wr, 1'($urandom_range(1)), 1'($urandom_range(1)),
              $urandom_range(1, 4), $urandom_range(1, 4), 1'b1, 1'b1);
      // Idle gaps with stray pmem_resp pulses, which must be ignored.
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++)
        step_check("random_idle", k, P_IDLE, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    pmem_resp = 1'b0;
    @(negedge clk);
    check_counters("random_end");
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_dirty_miss();
    test_both_high();
    test_reset_mid_fill();
    test_counter_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_cache_control
